// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM (IFETCH/DECODE/EXEC/MEM/WB/ERR), 3-5 cycles per instruction plus memory waits.
// Stalls in IFETCH/MEM until mem_ack or timeout; bltzal decode is optional via `MC_CTRL_BLTZAL_EN.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       zero,
  input  logic       carry,
  input  logic       less,
  input  logic       bltzal_0,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alusrc,
  output logic       addi,
  output logic [1:0] aluctr,
  output logic       reg_we,
  output logic       memtoreg,
  output logic [1:0] regdst,
  output logic       ovf,
  output logic       err
);

  localparam logic [2:0] S_IFETCH = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [3:0] OP_ADDU   = 4'd0;
  localparam logic [3:0] OP_SUBU   = 4'd1;
  localparam logic [3:0] OP_ORI    = 4'd2;
  localparam logic [3:0] OP_ADDI   = 4'd3;
  localparam logic [3:0] OP_LW     = 4'd4;
  localparam logic [3:0] OP_SW     = 4'd5;
  localparam logic [3:0] OP_BEQ    = 4'd6;
  localparam logic [3:0] OP_J      = 4'd7;
`ifdef MC_CTRL_BLTZAL_EN
  localparam logic [3:0] OP_BLTZAL = 4'd8;
`endif

  localparam logic [TW-1:0] CNT_LAST = TW'(MEM_TIMEOUT - 1);

  logic [2:0]    state, state_nxt;
  logic [3:0]    op_q, dec_op;
  logic          dec_ok;
  logic [TW-1:0] cnt;
  logic          wb_ovf;
  logic          mem_wait, timed_out;
  logic          unused_in;

  assign unused_in = ^{less, rt, bltzal_0};

  assign mem_wait  = (state == S_IFETCH) || (state == S_MEM);
  // The cycle that would push the count to MEM_TIMEOUT is the last one; an ack there still wins.
  assign timed_out = mem_wait && !mem_ack && (cnt == CNT_LAST);

  always_comb begin
    dec_op = OP_ADDU;
    dec_ok = 1'b0;
    case (opcode)
      6'b000000: begin
        if (funct == 6'b100001) begin
          dec_op = OP_ADDU;
          dec_ok = 1'b1;
        end else if (funct == 6'b100011) begin
          dec_op = OP_SUBU;
          dec_ok = 1'b1;
        end
      end
      6'b001101: begin dec_op = OP_ORI;  dec_ok = 1'b1; end
      6'b001000: begin dec_op = OP_ADDI; dec_ok = 1'b1; end
      6'b100011: begin dec_op = OP_LW;   dec_ok = 1'b1; end
      6'b101011: begin dec_op = OP_SW;   dec_ok = 1'b1; end
      6'b000100: begin dec_op = OP_BEQ;  dec_ok = 1'b1; end
      6'b000010: begin dec_op = OP_J;    dec_ok = 1'b1; end
`ifdef MC_CTRL_BLTZAL_EN
      6'b000001: begin
        if (rt == 5'b10000) begin
          dec_op = OP_BLTZAL;
          dec_ok = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IFETCH: begin
        if (mem_ack)        state_nxt = S_DECODE;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_DECODE: state_nxt = dec_ok ? S_EXEC : S_ERR;
      S_EXEC: begin
        case (op_q)
          OP_LW, OP_SW:  state_nxt = S_MEM;
          OP_BEQ, OP_J:  state_nxt = S_IFETCH;
`ifdef MC_CTRL_BLTZAL_EN
          OP_BLTZAL:     state_nxt = S_IFETCH;
`endif
          default:       state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ack)        state_nxt = (op_q == OP_LW) ? S_WB : S_IFETCH;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_WB:    state_nxt = S_IFETCH;
      default: state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IFETCH;
      cnt    <= '0;
      op_q   <= OP_ADDU;
      ovf    <= 1'b0;
      wb_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      // IFETCH and MEM are only ever entered from another state, so any transition clears the count.
      if (state_nxt != state)       cnt <= '0;
      else if (mem_wait && !mem_ack) cnt <= cnt + TW'(1);
      if (state == S_DECODE) op_q <= dec_op;
      if (state == S_EXEC) begin
        wb_ovf <= (op_q == OP_ADDI) && carry;
        if ((op_q == OP_ADDI) && carry) ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'b00;
    alusrc   = 1'b0;
    addi     = 1'b0;
    aluctr   = 2'b00;
    reg_we   = 1'b0;
    memtoreg = 1'b0;
    regdst   = 2'b00;
    err      = 1'b0;
    if (rst_n) begin
      // ALU controls stay stable from EXEC through MEM and WB.
      if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
        case (op_q)
          OP_SUBU, OP_BEQ: aluctr = 2'b01;
          OP_ORI: begin
            aluctr = 2'b10;
            alusrc = 1'b1;
          end
          OP_ADDI: begin
            alusrc = 1'b1;
            addi   = 1'b1;
          end
          OP_LW, OP_SW: alusrc = 1'b1;
`ifdef MC_CTRL_BLTZAL_EN
          OP_BLTZAL: aluctr = 2'b11;
`endif
          default: ;
        endcase
      end
      case (state)
        S_IFETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
          pc_we   = mem_ack;
        end
        S_EXEC: begin
          case (op_q)
            OP_BEQ: begin
              pc_we  = zero;
              pc_src = 2'b01;
            end
            OP_J: begin
              pc_we  = 1'b1;
              pc_src = 2'b10;
            end
`ifdef MC_CTRL_BLTZAL_EN
            OP_BLTZAL: begin
              pc_we  = bltzal_0;
              pc_src = 2'b01;
              reg_we = 1'b1;
              regdst = 2'b10;
            end
`endif
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (op_q == OP_SW);
        end
        S_WB: begin
          reg_we   = !wb_ovf;
          regdst   = ((op_q == OP_ADDU) || (op_q == OP_SUBU)) ? 2'b01 : 2'b00;
          memtoreg = (op_q == OP_LW);
        end
        S_ERR:   err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: timeout, each instruction class, overflow, memory waits, reset abort.
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic [4:0] rt;
  logic       zero, carry, less, bltzal_0, mem_ack;
  logic       mem_req, mem_we, ir_we, pc_we, alusrc, addi, reg_we, memtoreg, ovf, err;
  logic [1:0] pc_src, aluctr, regdst;

  int n_cmp = 0;
  int n_bad = 0;
  int req_cnt;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt),
    .zero(zero), .carry(carry), .less(less), .bltzal_0(bltzal_0), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alusrc(alusrc), .addi(addi), .aluctr(aluctr), .reg_we(reg_we), .memtoreg(memtoreg),
    .regdst(regdst), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ack = 1'b0; carry = 1'b0; zero = 1'b0; bltzal_0 = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // Fetch with ack in the first IFETCH cycle; returns in DECODE.
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
    opcode = op; funct = fn; rt = r; mem_ack = 1'b1;
    #1;
    chk("fetch_ir_we", 8'(ir_we), 8'd1);
    chk("fetch_pc_we", 8'(pc_we), 8'd1);
    chk("fetch_pc_src", 8'(pc_src), 8'd0);
    next_cyc();
    mem_ack = 1'b0;
    #1;
    chk("decode_mem_req", 8'(mem_req), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; rt = '0;
    zero = 1'b0; carry = 1'b0; less = 1'b0; bltzal_0 = 1'b0; mem_ack = 1'b0;
    #12;
    chk("rst_mem_req", 8'(mem_req), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    chk("rst_ovf", 8'(ovf), 8'd0);
    chk("rst_ir_we", 8'(ir_we), 8'd0);
    rst_n = 1'b1;
    #1;
    chk("release_mem_req", 8'(mem_req), 8'd1);

    // Fetch timeout: 16 unacknowledged cycles
    repeat (15) next_cyc();
    chk("to15_mem_req", 8'(mem_req), 8'd1);
    chk("to15_err", 8'(err), 8'd0);
    next_cyc();
    chk("to16_err", 8'(err), 8'd1);
    chk("to16_mem_req", 8'(mem_req), 8'd0);
    mem_ack = 1'b1;
    repeat (3) next_cyc();
    chk("err_hold", 8'(err), 8'd1);
    chk("err_mem_req", 8'(mem_req), 8'd0);
    chk("err_ir_we", 8'(ir_we), 8'd0);

    // Ack in the final allowed cycle beats the timeout
    do_reset();
    repeat (15) next_cyc();
    opcode = 6'b000010; mem_ack = 1'b1;
    #1;
    chk("ackwin_ir_we", 8'(ir_we), 8'd1);
    next_cyc();
    mem_ack = 1'b0;
    #1;
    chk("ackwin_err", 8'(err), 8'd0);
    next_cyc();
    chk("j_pc_we", 8'(pc_we), 8'd1);
    chk("j_pc_src", 8'(pc_src), 8'd2);
    next_cyc();
    chk("j_ifetch", 8'(mem_req), 8'd1);

    // addu
    fetch(6'b000000, 6'b100001, 5'd0);
    next_cyc();
    chk("addu_aluctr", 8'(aluctr), 8'd0);
    chk("addu_ex_reg_we", 8'(reg_we), 8'd0);
    chk("addu_alusrc", 8'(alusrc), 8'd0);
    next_cyc();
    chk("addu_wb_reg_we", 8'(reg_we), 8'd1);
    chk("addu_regdst", 8'(regdst), 8'd1);
    chk("addu_memtoreg", 8'(memtoreg), 8'd0);
    next_cyc();
    chk("addu_ifetch", 8'(mem_req), 8'd1);

    // subu
    fetch(6'b000000, 6'b100011, 5'd0);
    next_cyc();
    chk("subu_aluctr", 8'(aluctr), 8'd1);
    next_cyc();
    chk("subu_wb_aluctr", 8'(aluctr), 8'd1);
    chk("subu_regdst", 8'(regdst), 8'd1);
    next_cyc();

    // ori
    fetch(6'b001101, 6'd0, 5'd0);
    next_cyc();
    chk("ori_aluctr", 8'(aluctr), 8'd2);
    chk("ori_alusrc", 8'(alusrc), 8'd1);
    next_cyc();
    chk("ori_wb_alusrc", 8'(alusrc), 8'd1);
    chk("ori_regdst", 8'(regdst), 8'd0);
    chk("ori_reg_we", 8'(reg_we), 8'd1);
    next_cyc();

    // addi with overflow
    fetch(6'b001000, 6'd0, 5'd0);
    next_cyc();
    carry = 1'b1;
    #1;
    chk("addi_flag", 8'(addi), 8'd1);
    chk("addi_alusrc", 8'(alusrc), 8'd1);
    chk("addi_aluctr", 8'(aluctr), 8'd0);
    next_cyc();
    carry = 1'b0;
    #1;
    chk("addi_ovf", 8'(ovf), 8'd1);
    chk("addi_ovf_reg_we", 8'(reg_we), 8'd0);
    next_cyc();
    chk("addi_ovf_sticky", 8'(ovf), 8'd1);

    // addi without overflow still writes; ovf stays sticky
    fetch(6'b001000, 6'd0, 5'd0);
    next_cyc();
    next_cyc();
    chk("addi2_reg_we", 8'(reg_we), 8'd1);
    chk("addi2_ovf", 8'(ovf), 8'd1);
    next_cyc();

    // lw, ack on the 4th MEM cycle
    fetch(6'b100011, 6'd0, 5'd0);
    next_cyc();
    chk("lw_alusrc", 8'(alusrc), 8'd1);
    next_cyc();
    chk("lw_mem_we", 8'(mem_we), 8'd0);
    req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req) req_cnt++;
      next_cyc();
    end
    mem_ack = 1'b1;
    #1;
    if (mem_req) req_cnt++;
    next_cyc();
    mem_ack = 1'b0;
    #1;
    chk("lw_mem_req_cycles", 8'(req_cnt), 8'd4);
    chk("lw_memtoreg", 8'(memtoreg), 8'd1);
    chk("lw_regdst", 8'(regdst), 8'd0);
    chk("lw_reg_we", 8'(reg_we), 8'd1);
    chk("lw_wb_mem_req", 8'(mem_req), 8'd0);
    next_cyc();
    chk("lw_ifetch", 8'(mem_req), 8'd1);

    // sw completing normally
    fetch(6'b101011, 6'd0, 5'd0);
    next_cyc();
    next_cyc();
    chk("sw_mem_req", 8'(mem_req), 8'd1);
    chk("sw_mem_we", 8'(mem_we), 8'd1);
    mem_ack = 1'b1;
    #1;
    next_cyc();
    mem_ack = 1'b0;
    #1;
    chk("sw_ifetch_req", 8'(mem_req), 8'd1);
    chk("sw_ifetch_we", 8'(mem_we), 8'd0);
    chk("sw_no_reg_we", 8'(reg_we), 8'd0);

    // beq, taken and not taken in the same EXEC cycle
    fetch(6'b000100, 6'd0, 5'd0);
    next_cyc();
    zero = 1'b1;
    #1;
    chk("beq_pc_we_taken", 8'(pc_we), 8'd1);
    chk("beq_pc_src", 8'(pc_src), 8'd1);
    chk("beq_aluctr", 8'(aluctr), 8'd1);
    zero = 1'b0;
    #1;
    chk("beq_pc_we_not", 8'(pc_we), 8'd0);
    next_cyc();
    chk("beq_ifetch", 8'(mem_req), 8'd1);

    // bltzal
    fetch(6'b000001, 6'd0, 5'b10000);
    next_cyc();
`ifdef MC_CTRL_BLTZAL_EN
    bltzal_0 = 1'b1;
    #1;
    chk("bltzal_pc_we", 8'(pc_we), 8'd1);
    chk("bltzal_pc_src", 8'(pc_src), 8'd1);
    chk("bltzal_reg_we", 8'(reg_we), 8'd1);
    chk("bltzal_regdst", 8'(regdst), 8'd2);
    chk("bltzal_aluctr", 8'(aluctr), 8'd3);
    bltzal_0 = 1'b0;
    next_cyc();
    chk("bltzal_ifetch", 8'(mem_req), 8'd1);
`else
    chk("bltzal_off_err", 8'(err), 8'd1);
    chk("bltzal_off_aluctr", 8'(aluctr), 8'd0);
    do_reset();
`endif

    // Reset in the middle of a stalled sw
    fetch(6'b101011, 6'd0, 5'd0);
    next_cyc();
    next_cyc();
    next_cyc();
    chk("swrst_pre_req", 8'(mem_req), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("swrst_mem_req", 8'(mem_req), 8'd0);
    chk("swrst_mem_we", 8'(mem_we), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("swrst_restart_req", 8'(mem_req), 8'd1);
    chk("swrst_restart_we", 8'(mem_we), 8'd0);
    chk("swrst_ovf_clr", 8'(ovf), 8'd0);

    // Illegal opcode and illegal R-type funct
    fetch(6'b111111, 6'd0, 5'd0);
    next_cyc();
    chk("illegal_op_err", 8'(err), 8'd1);
    chk("illegal_op_reg_we", 8'(reg_we), 8'd0);
    do_reset();
    fetch(6'b000000, 6'b100000, 5'd0);
    next_cyc();
    chk("illegal_funct_err", 8'(err), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
